// File: rtl/bcd_pkg.sv
// Shared types and helpers for the binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bin2bcd_state_t;

    // Smallest digit count d with 10**d >= 2**width (valid for width < 120).
    function automatic int bcd_digits_for(input int width);
        logic [127:0] limit;
        logic [127:0] pow10;
        int           d;
        limit = 128'd1 << width;
        pow10 = 128'd1;
        d     = 0;
        for (int i = 0; i < 40; i++) begin
            if (pow10 < limit) begin
                pow10 = pow10 * 128'd10;
                d     = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adj
);

    assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-packed-BCD converter with valid/ready on both sides.
// Optional BIN2BCD_BLANK_EN adds a registered leading-zero blanking mask.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          In_valid,
    output logic                          In_ready,
    input  logic [BIN_WIDTH-1:0]          Bin,
    output logic                          Out_valid,
    input  logic                          Out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] Bcd,
    output logic                          Busy
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]             Blank
`endif
);

    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int WORK_W = BCD_W + BIN_WIDTH;
    localparam int CNT_W  = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    generate
        if (BIN_WIDTH < 1 || bcd_digits_for(BIN_WIDTH) > DIGITS) begin : g_bad_params
            $error("bin_to_bcd_seq: DIGITS=%0d too small for BIN_WIDTH=%0d", DIGITS, BIN_WIDTH);
        end
    endgenerate

    bin2bcd_state_t   state;
    logic [WORK_W-1:0] work;
    logic [WORK_W-1:0] adjusted;
    logic [WORK_W-1:0] shifted;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              unused_msb;

    // Work register: BCD digits above, remaining binary bits below.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_add3 u_add3 (
                .digit (work[BIN_WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
                .adj   (adjusted[BIN_WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign adjusted[BIN_WIDTH-1:0] = work[BIN_WIDTH-1:0];
    assign shifted    = {adjusted[WORK_W-2:0], 1'b0};
    assign unused_msb = adjusted[WORK_W-1];

    assign In_ready = (state == IDLE) || (state == DONE && Out_ready);
    assign accept   = In_valid && In_ready;
    assign Busy     = (state == SHIFT);

`ifdef BIN2BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));
    logic [DIGITS-1:0] blank_nxt;
    logic              zero_above;

    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above && (shifted[BIN_WIDTH + BCD_DIGIT_W*i +: BCD_DIGIT_W] == 4'd0);
            blank_nxt[i] = zero_above;
        end
    end
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            Out_valid <= 1'b0;
            Bcd       <= '0;
`ifdef BIN2BCD_BLANK_EN
            Blank     <= BLANK_RST;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work  <= {{BCD_W{1'b0}}, Bin};
                        cnt   <= CNT_W'(BIN_WIDTH - 1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    if (cnt == '0) begin
                        Bcd       <= shifted[WORK_W-1 -: BCD_W];
`ifdef BIN2BCD_BLANK_EN
                        Blank     <= blank_nxt;
`endif
                        Out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (Out_ready) begin
                        Out_valid <= 1'b0;
                        if (accept) begin
                            work  <= {{BCD_W{1'b0}}, Bin};
                            cnt   <= CNT_W'(BIN_WIDTH - 1);
                            state <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (default 8-bit / 3-digit build).
module tb_bin_to_bcd_seq;

    localparam int BW = 8;
    localparam int DG = 3;

    logic            Clk;
    logic            Rst_n;
    logic            In_valid;
    logic            In_ready;
    logic [BW-1:0]   Bin;
    logic            Out_valid;
    logic            Out_ready;
    logic [4*DG-1:0] Bcd;
    logic            Busy;
`ifdef BIN2BCD_BLANK_EN
    logic [DG-1:0]   Blank;
`endif

    bin_to_bcd_seq #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Bin       (Bin),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Bcd       (Bcd),
        .Busy      (Busy)
`ifdef BIN2BCD_BLANK_EN
        ,
        .Blank     (Blank)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time remaining on the conversion in flight, plus the result held.
    int              remaining;
    int              pending;
    logic            exp_valid;
    logic [4*DG-1:0] exp_bcd;
    logic [DG-1:0]   exp_blank;

    function automatic logic [4*DG-1:0] to_bcd(input int v);
        logic [4*DG-1:0] r;
        int              x;
        r = '0;
        x = v;
        for (int i = 0; i < DG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [DG-1:0] blank_of(input int v);
        logic [DG-1:0] b;
        int            p;
        b = '0;
        p = 1;
        for (int i = 1; i < DG; i++) begin
            p    = p * 10;
            b[i] = (v < p);
        end
        return b;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        remaining = 0;
        pending   = 0;
        exp_valid = 1'b0;
        exp_bcd   = '0;
        exp_blank = blank_of(0);
    endtask

    // One cycle: drive at negedge, compare against the model, advance model at posedge.
    task automatic step(input logic iv, input logic [BW-1:0] b, input logic ordy, output logic acc);
        logic exp_ir;
        logic hs;
        @(negedge Clk);
        In_valid  = iv;
        Bin       = b;
        Out_ready = ordy;
        #1;
        exp_ir = (remaining == 0) && (!exp_valid || ordy);
        check("in_ready",  32'(In_ready),  32'(exp_ir));
        check("out_valid", 32'(Out_valid), 32'(exp_valid));
        check("busy",      32'(Busy),      32'(remaining > 0));
        check("bcd",       32'(Bcd),       32'(exp_bcd));
`ifdef BIN2BCD_BLANK_EN
        check("blank",     32'(Blank),     32'(exp_blank));
`endif
        acc = iv && exp_ir;
        hs  = exp_valid && ordy;
        @(posedge Clk);
        if (hs) exp_valid = 1'b0;
        if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
                exp_valid = 1'b1;
                exp_bcd   = to_bcd(pending);
                exp_blank = blank_of(pending);
            end
        end
        if (acc) begin
            remaining = BW;
            pending   = int'(b);
        end
    endtask

    // Idle with Out_ready low until Out_valid; returns edges waited (-1 on timeout).
    task automatic wait_result(output int edges);
        logic acc;
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, '0, 1'b0, acc);
            #1;
            if (Out_valid) begin
                edges = k;
                break;
            end
        end
        if (edges < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_result: timed out waiting for out_valid at %0t", $time);
        end
    endtask

    initial begin
        logic acc;
        int   edges;
        int   v;
        int   cyc;

        Rst_n     = 1'b0;
        In_valid  = 1'b0;
        Bin       = '0;
        Out_ready = 1'b0;
        model_reset();

        // Model pinned against hand-computed values.
        check("model_255", 32'(to_bcd(255)), 32'h255);
        check("model_42",  32'(to_bcd(42)),  32'h042);
        check("model_blank_7",   32'(blank_of(7)),   32'b110);
        check("model_blank_100", 32'(blank_of(100)), 32'b000);

        repeat (2) @(negedge Clk);
        check("rst_out_valid", 32'(Out_valid), 32'h0);
        check("rst_bcd",       32'(Bcd),       32'h0);
        check("rst_in_ready",  32'(In_ready),  32'h1);
        check("rst_busy",      32'(Busy),      32'h0);
        Rst_n = 1'b1;

        // Max value, latency, return to ready.
        step(1'b1, 8'hFF, 1'b1, acc);
        check("ff_accepted", 32'(acc), 32'h1);
        wait_result(edges);
        check("ff_latency", 32'(edges), 32'd8);
        check("ff_bcd",     32'(Bcd),   32'h255);
        step(1'b0, '0, 1'b1, acc);
        #1;
        check("ff_in_ready_after", 32'(In_ready), 32'h1);

        // Zero and small values exercising blanking.
        step(1'b1, 8'd0, 1'b1, acc);
        wait_result(edges);
        check("zero_bcd", 32'(Bcd), 32'h000);
`ifdef BIN2BCD_BLANK_EN
        check("zero_blank", 32'(Blank), 32'b110);
`endif
        step(1'b1, 8'd7, 1'b1, acc);
        check("seven_accept_in_done", 32'(acc), 32'h1);
        wait_result(edges);
        check("seven_bcd", 32'(Bcd), 32'h007);
`ifdef BIN2BCD_BLANK_EN
        check("seven_blank", 32'(Blank), 32'b110);
`endif
        step(1'b0, '0, 1'b1, acc);

        // Backpressure then back-to-back accept.
        step(1'b1, 8'd42, 1'b0, acc);
        wait_result(edges);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'd99, 1'b0, acc);
            check("bp_no_accept", 32'(acc), 32'h0);
            #1;
            check("bp_bcd_stable", 32'(Bcd),      32'h042);
            check("bp_in_ready",   32'(In_ready), 32'h0);
        end
        step(1'b1, 8'd100, 1'b1, acc);
        check("b2b_accept", 32'(acc), 32'h1);
        wait_result(edges);
        check("b2b_latency", 32'(edges), 32'd8);
        check("b2b_bcd",     32'(Bcd),   32'h100);
`ifdef BIN2BCD_BLANK_EN
        check("b2b_blank", 32'(Blank), 32'b000);
`endif
        step(1'b0, '0, 1'b1, acc);

        // Reset during the 4th shift cycle discards the conversion.
        step(1'b1, 8'd200, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);
        @(negedge Clk);
        In_valid = 1'b0;
        #2;
        Rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_out_valid", 32'(Out_valid), 32'h0);
        check("mid_rst_bcd",       32'(Bcd),       32'h0);
        check("mid_rst_in_ready",  32'(In_ready),  32'h1);
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, acc);
        step(1'b1, 8'h7F, 1'b1, acc);
        wait_result(edges);
        check("post_rst_bcd", 32'(Bcd), 32'h127);
        step(1'b0, '0, 1'b1, acc);

        // Exhaustive sweep with random gaps and output stalls.
        v   = 0;
        cyc = 0;
        while (v < 256 && cyc < 20000) begin
            step(($urandom % 4) != 0, BW'(v), ($urandom % 3) != 0, acc);
            if (acc) v++;
            cyc++;
        end
        check("sweep_complete", 32'(v), 32'd256);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
